// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial w-line transmitter and detector benches.
// State encodings are exposed as localparams so detector benches can decode them.
package serial_pattern_tx_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        StIdle   = ST_IDLE,
        StShift  = ST_SHIFT,
        StParity = ST_PARITY,
        StDone   = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Load handshake plus serial w-line bundle for serial_pattern_tx.
// master drives patterns in; slave is the transmitter.
interface serial_pattern_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             w;
    logic             w_valid;
    logic             busy;
    logic             done;
    logic             exp_z;

    modport master (
        output load_valid, load_data,
        input  load_ready, w, w_valid, busy, done, exp_z
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, w, w_valid, busy, done, exp_z
    );
endinterface

// File: rtl/serial_pattern_tx_run_model.sv
// Golden model of a two-equal-bits run detector: exp_z is high in cycle t when the bits
// sent in t-1 and t-2 both belong to the current frame and are equal.
module serial_pattern_tx_run_model (
    input  logic clk,
    input  logic reset,
    input  logic w,
    input  logic w_valid,
    input  logic clear,
    output logic exp_z
);
    logic prev_q;
    logic prev_valid_q;
    logic exp_z_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            exp_z_q      <= 1'b0;
        end else if (clear) begin
            prev_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            exp_z_q      <= 1'b0;
        end else begin
            prev_q       <= w;
            prev_valid_q <= w_valid;
            exp_z_q      <= w_valid && prev_valid_q && (w == prev_q);
        end
    end

    assign exp_z = exp_z_q;
endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern MSB-first on w, then pulses done.
// Define PARITY_BIT_EN to append an even-parity bit after the last data bit.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic               clk,
    input logic               reset,
    serial_pattern_tx_if.slave bus
);
    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CNT_W-1:0] count_q;
    logic             w_q;
    logic             w_valid_q;
    logic             done_q;
    logic             ready_q;
`ifdef PARITY_BIT_EN
    logic             parity_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            count_q   <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef PARITY_BIT_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.load_valid && ready_q) begin
                        // First bit goes out directly; the register holds the remainder.
                        state_q   <= StShift;
                        w_q       <= bus.load_data[WIDTH-1];
                        w_valid_q <= 1'b1;
                        shreg_q   <= bus.load_data << 1;
                        count_q   <= '0;
                        ready_q   <= 1'b0;
`ifdef PARITY_BIT_EN
                        parity_q  <= ^bus.load_data;
`endif
                    end
                end
                StShift: begin
                    if (count_q == CNT_W'(WIDTH - 1)) begin
`ifdef PARITY_BIT_EN
                        state_q   <= StParity;
                        w_q       <= parity_q;
`else
                        state_q   <= StDone;
                        w_q       <= 1'b0;
                        w_valid_q <= 1'b0;
                        done_q    <= 1'b1;
`endif
                    end else begin
                        w_q     <= shreg_q[WIDTH-1];
                        shreg_q <= shreg_q << 1;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
`ifdef PARITY_BIT_EN
                StParity: begin
                    state_q   <= StDone;
                    w_q       <= 1'b0;
                    w_valid_q <= 1'b0;
                    done_q    <= 1'b1;
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                    count_q <= '0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= StIdle;
                    w_q       <= 1'b0;
                    w_valid_q <= 1'b0;
                    ready_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.load_ready = ready_q;
    assign bus.w          = w_q;
    assign bus.w_valid    = w_valid_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;

    serial_pattern_tx_run_model u_run_model (
        .clk     (clk),
        .reset   (reset),
        .w       (w_q),
        .w_valid (w_valid_q),
        .clear   (state_q == StIdle),
        .exp_z   (bus.exp_z)
    );
endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx; honours PARITY_BIT_EN when defined.
module tb_serial_pattern_tx;
    localparam int unsigned WIDTH = 8;
`ifdef PARITY_BIT_EN
    localparam int unsigned NPAR = 1;
`else
    localparam int unsigned NPAR = 0;
`endif
    localparam int unsigned FRAME = WIDTH + NPAR + 1;
    localparam logic [5:0] IDLE_OBS = 6'b000001;

    typedef struct packed {
        logic w;
        logic wv;
        logic z;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_pattern_tx_if #(.WIDTH(WIDTH)) tx ();

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tx)
    );

    // Independent one-hot run detector {two 1s, two 0s, last 1, last 0, empty}.
    logic [4:0] det_q;
    logic       det_z;
    assign det_z = det_q[3] | det_q[4];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) det_q <= 5'b00001;
        else if (!tx.w_valid) det_q <= 5'b00001;
        else if (tx.w) det_q <= (det_q[2] | det_q[4]) ? 5'b10000 : 5'b00100;
        else det_q <= (det_q[1] | det_q[3]) ? 5'b01000 : 5'b00010;
    end

    function automatic logic [5:0] obs();
        obs = {tx.w, tx.w_valid, tx.exp_z, tx.done, tx.busy, tx.load_ready};
    endfunction

    function automatic logic [5:0] expv(input exp_t e);
        expv = {e.w, e.wv, e.z, e.done, 2'b10};
    endfunction

    // Push one record per cycle from first bit through the DONE cycle.
    task automatic push_frame(input logic [WIDTH-1:0] d);
        logic [WIDTH:0] bits;
        exp_t e;
        for (int i = 0; i < WIDTH; i++) bits[i] = d[WIDTH-1-i];
        bits[WIDTH] = ^d;
        for (int k = 1; k <= int'(FRAME); k++) begin
            e.wv   = (k <= int'(WIDTH + NPAR));
            e.w    = e.wv ? bits[k-1] : 1'b0;
            e.done = (k == int'(FRAME));
            e.z    = (k >= 3) ? (bits[k-2] == bits[k-3]) : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic start_frame(input logic [WIDTH-1:0] d);
        tx.load_data  = d;
        tx.load_valid = 1'b1;
        push_frame(d);
        @(posedge clk); #1;
        tx.load_valid = 1'b0;
    endtask

    task automatic test_reset();
        int dones;
        tx.load_valid = 1'b0;
        tx.load_data  = '0;
        reset = 1'b0;
        #12;
        total++;
        if (obs() !== IDLE_OBS) begin
            bad++; $display("FAIL reset_hold: got %b expected %b", obs(), IDLE_OBS);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if (obs() !== IDLE_OBS) begin
            bad++; $display("FAIL reset_release: got %b expected %b", obs(), IDLE_OBS);
        end
        reset = 1'b0; #2;
        total++;
        if (obs() !== IDLE_OBS) begin
            bad++; $display("FAIL reset_idle: got %b expected %b", obs(), IDLE_OBS);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        start_frame(8'hC3);
        repeat (3) @(posedge clk);
        #3; reset = 1'b0; #1;
        exp_q.delete();
        total++;
        if (obs() !== IDLE_OBS) begin
            bad++; $display("FAIL reset_midframe: got %b expected %b", obs(), IDLE_OBS);
        end
        #2; reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (tx.done || tx.busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("FAIL reset_no_done: got %0d active cycles expected 0", dones);
        end
    endtask

    task automatic test_pattern();
        exp_t e;
        start_frame(8'b0011_0110);
        for (int k = 1; k <= int'(FRAME); k++) begin
            e = exp_q.pop_front();
            total++;
            if (obs() !== expv(e)) begin
                bad++; $display("FAIL pattern c%0d: got %b expected %b", k, obs(), expv(e));
            end
            @(posedge clk); #1;
        end
        total++;
        if (obs() !== IDLE_OBS) begin
            bad++; $display("FAIL pattern_idle: got %b expected %b", obs(), IDLE_OBS);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        tx.load_data  = 8'hFF;
        tx.load_valid = 1'b1;
        push_frame(8'hFF);
        @(posedge clk); #1;
        tx.load_data = 8'h00;
        for (int k = 1; k <= int'(FRAME); k++) begin
            e = exp_q.pop_front();
            total++;
            if (obs() !== expv(e)) begin
                bad++; $display("FAIL b2b_f1 c%0d: got %b expected %b", k, obs(), expv(e));
            end
            @(posedge clk); #1;
        end
        total++;
        if (obs() !== IDLE_OBS) begin
            bad++; $display("FAIL b2b_gap: got %b expected %b", obs(), IDLE_OBS);
        end
        push_frame(8'h00);
        @(posedge clk); #1;
        tx.load_valid = 1'b0;
        for (int k = 1; k <= int'(FRAME); k++) begin
            e = exp_q.pop_front();
            total++;
            if (obs() !== expv(e)) begin
                bad++; $display("FAIL b2b_f2 c%0d: got %b expected %b", k, obs(), expv(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_load();
        exp_t e;
        start_frame(8'h3C);
        for (int k = 1; k <= int'(FRAME); k++) begin
            e = exp_q.pop_front();
            total++;
            if (obs() !== expv(e)) begin
                bad++; $display("FAIL ignore c%0d: got %b expected %b", k, obs(), expv(e));
            end
            if (k == 3) begin
                tx.load_data  = 8'hA5;
                tx.load_valid = 1'b1;
            end else begin
                tx.load_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (obs() !== IDLE_OBS) begin
                bad++; $display("FAIL ignore_idle%0d: got %b expected %b", k, obs(), IDLE_OBS);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_detector();
        exp_t e;
        logic [WIDTH-1:0] d;
        for (int n = 0; n < 6; n++) begin
            d = (n == 0) ? 8'b0011_0110 : (n == 1) ? 8'hAA : WIDTH'($urandom);
            start_frame(d);
            for (int k = 1; k <= int'(FRAME); k++) begin
                e = exp_q.pop_front();
                total++;
                if (obs() !== expv(e) || det_z !== tx.exp_z) begin
                    bad++;
                    $display("FAIL detector f%0d c%0d: got %b det_z=%b expected %b", n, k,
                             obs(), det_z, expv(e));
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected test completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pattern();
        test_back_to_back();
        test_ignore_load();
        test_detector();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
